// File: rtl/dequant_pkg.sv
// Shared definitions for the 4x4 rescaler: position classes, V table, saturation.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package dequant_pkg;

    typedef enum logic [1:0] {
        A = 2'd0,
        B = 2'd1,
        C = 2'd2
    } pos_class_t;

    // Width of the intermediate value handed to sat(); wide enough for the
    // shifted product of the default configuration.
    localparam int SAT_W = 32;

    // Rescale factor V, rows by position class (A, B, C), columns by QP%6.
    localparam logic [4:0] V_TAB [3][6] = '{
        '{5'd10, 5'd11, 5'd13, 5'd14, 5'd16, 5'd18},
        '{5'd16, 5'd18, 5'd20, 5'd23, 5'd25, 5'd29},
        '{5'd13, 5'd14, 5'd16, 5'd18, 5'd20, 5'd23}
    };

    function automatic pos_class_t pos_class(input logic [3:0] pos);
        case (pos)
            4'd0, 4'd2, 4'd8, 4'd10:  return A;
            4'd5, 4'd7, 4'd13, 4'd15: return B;
            default:                  return C;
        endcase
    endfunction

    // Clamp a signed value to the range of a signed word of 'width' bits.
    function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] value,
                                                    input int width);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = $signed((32'd1 << (width - 1)) - 32'd1);
        lo = ~hi;
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/dequant_scale_lut.sv
// Maps (raster position, QP%6) to the rescale factor V; illegal QP%6 reads as 0.
// Latency: combinational.
// Backpressure: none (pure lookup).
module dequant_scale_lut
    import dequant_pkg::*;
(
    input  logic [3:0] pos_i,
    input  logic [2:0] qp_mod_6_i,
    output logic [4:0] v_o,
    output logic       illegal_o
);

    logic [2:0] mod_eff;
    pos_class_t cls;

    // Sanitize QP%6 and index the V table by position class.
    always_comb begin
        illegal_o = (qp_mod_6_i > 3'd5);
        mod_eff   = illegal_o ? 3'd0 : qp_mod_6_i;
        cls       = pos_class(pos_i);
        v_o       = V_TAB[cls][mod_eff];
    end

endmodule

// File: rtl/dequant_4x4.sv
// Streaming 4x4 inverse quantizer: W = sat(Z * V(QP%6,pos) << QP/6), raster order.
// Latency: 2 cycles (multiply stage, shift/saturate stage), 1 coefficient/cycle.
// Backpressure: valid/ready both sides; in_ready is combinational from out_ready (no skid).
module dequant_4x4
    import dequant_pkg::*;
#(
    parameter int BIT_LENGTH  = 15,
    parameter int MAX_QP_BY_6 = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIT_LENGTH:0]   in_coeff,
    input  logic [3:0]            QP_BY_6,
    input  logic [2:0]            QP_MOD_6,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIT_LENGTH:0]   out_coeff,
    output logic [3:0]            out_index,
    output logic                  out_last,
    output logic                  qp_err
);

    localparam int CW = BIT_LENGTH + 1;
    localparam int PW = BIT_LENGTH + 7;
    localparam int FW = BIT_LENGTH + 1 + 6 + MAX_QP_BY_6;
    localparam logic [3:0] MAX_SHIFT = 4'(MAX_QP_BY_6);

    logic [3:0]           pos_q, pos_d;
    logic [3:0]           qp_by6_q, qp_by6_d;
    logic [2:0]           qp_mod6_q, qp_mod6_d;
    logic                 qp_err_q, qp_err_d;
    logic                 s1_vld_q, s1_vld_d;
    logic signed [PW-1:0] s1_prod_q, s1_prod_d;
    logic [3:0]           s1_idx_q, s1_idx_d;
    logic [3:0]           s1_shift_q, s1_shift_d;
    logic                 s2_vld_q, s2_vld_d;
    logic [CW-1:0]        out_coeff_q, out_coeff_d;
    logic [3:0]           out_idx_q, out_idx_d;
    logic                 out_last_q, out_last_d;

    logic                    s1_adv, s2_adv, in_xfer, pos0;
    logic [3:0]              by6_clamped, by6_eff;
    logic [2:0]              mod6_eff;
    logic [4:0]              v;
    logic                    illegal;
    logic signed [PW-1:0]    z_ext, v_ext, prod;
    logic signed [FW-1:0]    full_ext, shifted;
    logic signed [SAT_W-1:0] wide;

    // Index 0 uses the live QP inputs; the rest of the block uses the latch.
    dequant_scale_lut u_lut (
        .pos_i      (pos_q),
        .qp_mod_6_i (mod6_eff),
        .v_o        (v),
        .illegal_o  (illegal)
    );

    // Handshake, effective QP selection and the datapath of both stages.
    always_comb begin
        s2_adv      = enable && (!s2_vld_q || out_ready);
        s1_adv      = enable && (!s1_vld_q || s2_adv);
        in_xfer     = in_valid && s1_adv;
        pos0        = (pos_q == 4'd0);
        by6_clamped = (QP_BY_6 > MAX_SHIFT) ? MAX_SHIFT : QP_BY_6;
        by6_eff     = pos0 ? by6_clamped : qp_by6_q;
        mod6_eff    = pos0 ? QP_MOD_6 : qp_mod6_q;
        z_ext       = {{(PW-CW){in_coeff[BIT_LENGTH]}}, in_coeff};
        v_ext       = {{(PW-5){1'b0}}, v};
        prod        = z_ext * v_ext;
        full_ext    = {{(FW-PW){s1_prod_q[PW-1]}}, s1_prod_q};
        shifted     = full_ext <<< s1_shift_q;
        wide        = {{(SAT_W-FW){shifted[FW-1]}}, shifted};
    end

    // Next state: position counter, QP latch, stage 1 and stage 2 loads.
    always_comb begin
        pos_d       = pos_q;
        qp_by6_d    = qp_by6_q;
        qp_mod6_d   = qp_mod6_q;
        qp_err_d    = in_xfer && pos0 && illegal;
        s1_vld_d    = s1_vld_q;
        s1_prod_d   = s1_prod_q;
        s1_idx_d    = s1_idx_q;
        s1_shift_d  = s1_shift_q;
        s2_vld_d    = s2_vld_q;
        out_coeff_d = out_coeff_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        if (in_xfer) begin
            pos_d = pos_q + 4'd1;
            if (pos0) begin
                qp_by6_d  = by6_clamped;
                qp_mod6_d = illegal ? 3'd0 : QP_MOD_6;
            end
        end
        if (s1_adv) begin
            s1_vld_d = in_valid;
            if (in_valid) begin
                s1_prod_d  = prod;
                s1_idx_d   = pos_q;
                s1_shift_d = by6_eff;
            end
        end
        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                out_coeff_d = CW'(sat(wide, CW));
                out_idx_d   = s1_idx_q;
                out_last_d  = (s1_idx_q == 4'd15);
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pos_q       <= '0;
            qp_by6_q    <= '0;
            qp_mod6_q   <= '0;
            qp_err_q    <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_prod_q   <= '0;
            s1_idx_q    <= '0;
            s1_shift_q  <= '0;
            s2_vld_q    <= 1'b0;
            out_coeff_q <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            pos_q       <= pos_d;
            qp_by6_q    <= qp_by6_d;
            qp_mod6_q   <= qp_mod6_d;
            qp_err_q    <= qp_err_d;
            s1_vld_q    <= s1_vld_d;
            s1_prod_q   <= s1_prod_d;
            s1_idx_q    <= s1_idx_d;
            s1_shift_q  <= s1_shift_d;
            s2_vld_q    <= s2_vld_d;
            out_coeff_q <= out_coeff_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_vld_q;
    assign out_coeff = out_coeff_q;
    assign out_index = out_idx_q;
    assign out_last  = out_last_q;
    assign qp_err    = qp_err_q;

endmodule

// File: tb/tb_dequant_4x4.sv
// Directed bench for dequant_4x4 with hand-computed expected coefficients.
// Latency: n/a.
// Backpressure: exercises out_ready stalls and enable freezes.
module tb_dequant_4x4;

    logic        clk = 1'b0;
    logic        reset, enable, in_valid, out_ready;
    logic        in_ready, out_valid, out_last, qp_err;
    logic [15:0] in_coeff, out_coeff;
    logic [3:0]  QP_BY_6, out_index;
    logic [2:0]  QP_MOD_6;

    typedef struct {
        int c;
        int idx;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   qp_err_cnt = 0;
    int   tb_pos = 0;

    // Position class per raster index: 0 = A, 1 = B, 2 = C.
    localparam int CLS [16] = '{0, 2, 0, 2, 2, 1, 2, 1, 0, 2, 0, 2, 2, 1, 2, 1};

    dequant_4x4 dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coeff  (in_coeff),
        .QP_BY_6   (QP_BY_6),
        .QP_MOD_6  (QP_MOD_6),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_coeff (out_coeff),
        .out_index (out_index),
        .out_last  (out_last),
        .qp_err    (qp_err)
    );

    always #5 clk = ~clk;

    function automatic int pick(int p, int a, int b, int c);
        return (CLS[p] == 0) ? a : (CLS[p] == 1) ? b : c;
    endfunction

    task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Present one coefficient and wait (bounded) for it to be accepted.
    task automatic send(int z, int qb, int qm, int exp_c);
        int n;
        exp_t e;
        in_coeff = 16'(z);
        QP_BY_6  = 4'(qb);
        QP_MOD_6 = 3'(qm);
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $error("FAIL in_ready_timeout observed=0 expected=1 pos=%0d", tb_pos);
        end else begin
            e.c   = exp_c;
            e.idx = tb_pos;
            exp_q.push_back(e);
            @(posedge clk); #1;
            tb_pos = (tb_pos + 1) % 16;
        end
        in_valid = 1'b0;
    endtask

    // Output monitor: every accepted output must match the next expected entry.
    always @(negedge clk) begin
        if (qp_err === 1'b1) qp_err_cnt++;
        if (reset && enable && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_out observed_index=%0d expected=none", out_index);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_coeff", $signed(out_coeff), mon_e.c);
                chk("out_index", {28'd0, out_index}, mon_e.idx);
                chk("out_last", {31'd0, out_last}, (mon_e.idx == 15) ? 1 : 0);
            end
        end
    end

    initial begin
        int z, qb, qm, e, n;
        reset = 1'b0; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_coeff = '0; QP_BY_6 = '0; QP_MOD_6 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_coeff", {16'd0, out_coeff}, 0);
        chk("rst_out_index", {28'd0, out_index}, 0);
        chk("rst_out_last", {31'd0, out_last}, 0);
        chk("rst_qp_err", {31'd0, qp_err}, 0);
        reset = 1'b1;
        #1;
        chk("idle_in_ready", {31'd0, in_ready}, 1);

        // Block 1: QP 28, Z = 1 everywhere.
        for (int p = 0; p < 16; p++) send(1, 4, 4, pick(p, 256, 400, 320));

        // Block 2: QP 28 with signed/scaled values and a 5-cycle output stall.
        for (int p = 0; p < 16; p++) begin
            z = (p == 1) ? 2 : (p == 5) ? -3 : 1;
            e = (p == 1) ? 640 : (p == 5) ? -1200 : pick(p, 256, 400, 320);
            if (p == 5) begin
                out_ready = 1'b0;
                in_coeff = 16'(z); QP_BY_6 = 4'd4; QP_MOD_6 = 3'd4; in_valid = 1'b1;
                #1;
                chk("stall_in_ready", {31'd0, in_ready}, 0);
                repeat (5) begin
                    @(posedge clk); #1;
                    chk("stall_out_valid", {31'd0, out_valid}, 1);
                    chk("stall_out_index", {28'd0, out_index}, 3);
                    chk("stall_out_coeff", $signed(out_coeff), 320);
                    chk("stall_in_ready", {31'd0, in_ready}, 0);
                end
                out_ready = 1'b1;
            end
            send(z, 4, 4, e);
        end

        // Block 3 back-to-back: QP 13 latched at index 0, inputs changed from index 7.
        for (int p = 0; p < 16; p++) begin
            qb = (p < 7) ? 2 : 8;
            qm = (p < 7) ? 1 : 5;
            send(3, qb, qm, pick(p, 132, 216, 168));
        end

        // Block 4: maximum shift, saturation at both ends.
        for (int p = 0; p < 16; p++) begin
            z = (p == 0) ? -1 : (p == 1) ? 1 : (p == 5) ? 32767 : (p == 7) ? -32768 : 0;
            e = (p == 0) ? -4608 : (p == 1) ? 5888 : (p == 5) ? 32767 : (p == 7) ? -32768 : 0;
            send(z, 8, 5, e);
        end

        // Block 5: illegal QP%6 at index 0 -> V for QP%6 = 0, plus an enable freeze.
        for (int p = 0; p < 16; p++) begin
            qm = (p == 0) ? 6 : (p == 3) ? 7 : 0;
            if (p == 5) begin
                enable = 1'b0;
                in_coeff = 16'd1; in_valid = 1'b1;
                #1;
                chk("frz_in_ready", {31'd0, in_ready}, 0);
                repeat (2) begin
                    @(posedge clk); #1;
                    chk("frz_out_valid", {31'd0, out_valid}, 1);
                    chk("frz_out_index", {28'd0, out_index}, 3);
                    chk("frz_out_coeff", $signed(out_coeff), 13);
                end
                enable = 1'b1;
            end
            send(1, 0, qm, pick(p, 10, 16, 13));
            if (p == 0) chk("qp_err_pulse", {31'd0, qp_err}, 1);
            if (p == 1) chk("qp_err_clear", {31'd0, qp_err}, 0);
        end

        // Block 6: partial block aborted by reset at position 9.
        for (int p = 0; p < 9; p++) send(1, 4, 4, pick(p, 256, 400, 320));
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
        chk("mid_rst_out_coeff", {16'd0, out_coeff}, 0);
        chk("mid_rst_out_index", {28'd0, out_index}, 0);
        chk("mid_rst_out_last", {31'd0, out_last}, 0);
        exp_q.delete();
        tb_pos = 0;
        reset = 1'b1;

        // Fresh block after reset: QP 8 (QP/6 = 1, QP%6 = 2).
        for (int p = 0; p < 16; p++) begin
            send(1, 1, 2, pick(p, 26, 40, 32));
            if (p == 1) begin
                chk("fresh_out_valid", {31'd0, out_valid}, 1);
                chk("fresh_out_index", {28'd0, out_index}, 0);
                chk("fresh_out_coeff", $signed(out_coeff), 26);
            end
        end

        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("lost_outputs", exp_q.size(), 0);
        chk("qp_err_pulses", qp_err_cnt, 1);
        chk("end_out_valid", {31'd0, out_valid}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dequant_4x4.md
# dequant_4x4

Streaming inverse quantizer (rescaler) for 4x4 integer-transform blocks in the TransformCoding path: the decoder-side counterpart of the forward quantizer. Accepts 16 quantized levels per block, one per cycle in raster order, and produces rescaled coefficients `W = Z * V(QP%6, pos) << (QP/6)` for the inverse transform. The pipeline has two stages, a valid/ready handshake on both sides, and saturation to the coefficient width.

## Interface
- `BIT_LENGTH`, 15: coefficient MSB index. Input and output words are `BIT_LENGTH+1` bits, signed two's complement.
- `MAX_QP_BY_6`, 8: largest legal shift (QP 0..51). Larger `QP_BY_6` values are clamped to this.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `enable`  in  1  pipeline advance enable. Low freezes all state and forces `in_ready` low.
- `in_valid`  in  1  `in_coeff` is valid.
- `in_ready`  out  1  block can accept a coefficient this cycle.
- `in_coeff`  in  `BIT_LENGTH+1`  quantized level Z, signed.
- `QP_BY_6`  in  4  QP/6. Sampled with coefficient index 0 only.
- `QP_MOD_6`  in  3  QP%6. Sampled with coefficient index 0 only.
- `out_valid`  out  1  `out_coeff` is valid.
- `out_ready`  in  1  downstream accepts `out_coeff`.
- `out_coeff`  out  `BIT_LENGTH+1`  rescaled coefficient, signed, saturated.
- `out_index`  out  4  raster position (0..15) of `out_coeff`.
- `out_last`  out  1  high when `out_index == 15`.
- `qp_err`  out  1  one-cycle pulse when index 0 is accepted with `QP_MOD_6 > 5`.

## Operation
- Transfer occurs on a cycle with `valid && ready && enable`. Coefficients arrive in raster order.
- Internal position counter `pos` (4 bits):
  - starts at 0;
  - increments on each input transfer;
  - wraps 15 -> 0, which marks the block boundary.
- QP latch: on the transfer with `pos == 0`, `QP_BY_6` and `QP_MOD_6` are registered. Changes to these inputs at other positions are ignored until the next block.
- Illegal `QP_MOD_6` (6 or 7): treated as 0 for the whole block, and `qp_err` pulses.
- Position class:
  - A: positions 0, 2, 8, 10.
  - B: positions 5, 7, 13, 15.
  - C: all other positions.
- V table, indexed by QP%6 = 0..5:
  - A: 10, 11, 13, 14, 16, 18.
  - B: 16, 18, 20, 23, 25, 29.
  - C: 13, 14, 16, 18, 20, 23.
- Stage 1: `prod = Z * V`, signed, `BIT_LENGTH+7` bits. The stage also carries the position and the latched shift.
- Stage 2: `full = prod <<< shift` at `BIT_LENGTH+1+6+MAX_QP_BY_6` bits, then saturate to [-2^BIT_LENGTH, 2^BIT_LENGTH - 1]. No rounding, since the left shift is exact.
- Sign handling is arithmetic throughout: a negative Z gives `-(|Z|*V) << shift` exactly.

## Timing
- Latency: an input accepted at cycle N appears on `out_*` at cycle N+2 if there is no backpressure.
- Throughput: 1 coefficient per cycle.
- Stage register advance rules:
  - Stage 2 advances when `enable && (!s2_valid || out_ready)`.
  - Stage 1 advances when `enable && (!s1_valid || s2_advance)`.
  - `in_ready = enable && (!s1_valid || s2_advance)`. This is combinational from `out_ready`; no skid buffer.
- While `out_valid && !out_ready`, all `out_*` outputs hold stable.
- If a back-to-back block starts while the prior block is still in flight, each in-flight coefficient uses the QP latched with its own block. This requires per-stage copies of the shift and V.
- Reset (`reset == 0` at a clock edge), including mid-block:
  - `pos = 0`; `s1_valid = s2_valid = 0`;
  - `out_valid = 0`, `out_coeff = 0`, `out_index = 0`, `out_last = 0`, `qp_err = 0`;
  - the QP latch clears to 0/0;
  - any partial block is discarded.
- Clock states: counting, frozen (`enable == 0`), held (backpressure). `pos` changes only on input transfers.

## Structure
- Package `dequant_pkg`:
  - `pos_class_t` enum {A, B, C};
  - function `pos_class(pos)`;
  - constant V table, 3x6, 5-bit entries;
  - function `sat(value, width)`.
- Sub-module `dequant_scale_lut`: combinational (`pos`, `qp_mod_6`) -> V[4:0] plus an illegal flag. It is shared with any future 8x8 or DC rescaler variant.
- Top level: position counter, QP latch, two pipeline stages, handshake logic.

## Test plan
- QP = 28 (`QP_BY_6 = 4`, `QP_MOD_6 = 4`), Z = 1 at all 16 positions -> outputs 256 at class A, 400 at class B, 320 at class C. `out_last` is high only at index 15.
- QP = 28, Z = -3 at position 5 -> -1200. Z = 2 at position 1 -> 640.
- `QP_BY_6 = 8`, `QP_MOD_6 = 5`, Z = 32767 at position 5 -> 32767. Z = -32768 -> -32768.
- `out_ready` low for 5 cycles mid-block -> `in_ready` drops after the pipeline fills, `out_*` hold, and no coefficient is lost or duplicated across 2 back-to-back blocks with different QP.
- QP changed at position 7 -> values unchanged for positions 7..15. `QP_MOD_6 = 6` at index 0 -> `qp_err` pulses once and the block uses V for QP%6 = 0.
- `reset` asserted at position 9, then a fresh block -> no stale outputs, and the first output has `out_index = 0` with the new QP.
